// File: rtl/rbcp_initiator.sv
// RBCP initiator: converts local byte-burst requests into RBCP ACT/ADDR/WD/WE/RE
// cycles, one byte per strobe, and waits for the responder's ACK with a timeout.
module rbcp_initiator #(
    parameter int TIMEOUT  = 1000,
    parameter int TO_WIDTH = 16
) (
    input  logic        BUS_CLK,
    input  logic        BUS_RST_N,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic        REQ_WRITE,
    input  logic [31:0] REQ_ADDR,
    input  logic [7:0]  REQ_LEN,
    input  logic [7:0]  WR_DATA,
    input  logic        WR_VALID,
    output logic        WR_READY,
    output logic [7:0]  RD_DATA,
    output logic        RD_VALID,
    output logic        DONE,
    output logic        ERR,
    output logic        BUSY,
    output logic        RBCP_ACT,
    output logic [31:0] RBCP_ADDR,
    output logic [7:0]  RBCP_WD,
    output logic        RBCP_WE,
    output logic        RBCP_RE,
    input  logic        RBCP_ACK,
    input  logic [7:0]  RBCP_RD
);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_FETCH, S_GAP, S_STROBE, S_WAIT_ACK, S_FINISH
    } state_t;

    state_t              state, state_nxt;
    logic                is_write;
    logic [7:0]          remaining;
    logic                err_flag;
    logic [TO_WIDTH-1:0] to_cnt;
    logic                timed_out;

    // The count reaches TIMEOUT on the same edge that leaves WAIT_ACK.
    assign timed_out = (to_cnt == TO_WIDTH'(TIMEOUT - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) state <= S_IDLE;
        else            state <= state_nxt;
    end

    // NOTE: every output and state_nxt gets a default first so no path through
    // the case statement can leave a value unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        REQ_READY = 1'b0;
        WR_READY  = 1'b0;
        BUSY      = 1'b1;
        RBCP_ACT  = 1'b0;
        RBCP_WE   = 1'b0;
        RBCP_RE   = 1'b0;
        DONE      = 1'b0;
        ERR       = 1'b0;
        case (state)
            S_IDLE: begin
                REQ_READY = 1'b1;
                BUSY      = 1'b0;
                if (REQ_VALID) state_nxt = (REQ_LEN == 8'd0) ? S_FINISH : S_SETUP;
            end
            S_SETUP: begin
                RBCP_ACT  = 1'b1;
                state_nxt = is_write ? S_FETCH : S_STROBE;
            end
            S_FETCH: begin
                RBCP_ACT = 1'b1;
                WR_READY = 1'b1;
                if (WR_VALID) state_nxt = S_STROBE;
            end
            S_GAP: begin
                RBCP_ACT  = 1'b1;
                state_nxt = S_STROBE;
            end
            S_STROBE: begin
                RBCP_ACT  = 1'b1;
                RBCP_WE   = is_write;
                RBCP_RE   = !is_write;
                state_nxt = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                RBCP_ACT = 1'b1;
                if (RBCP_ACK) begin
                    if (remaining == 8'd1) state_nxt = S_FINISH;
                    else                   state_nxt = is_write ? S_FETCH : S_GAP;
                end else if (timed_out) begin
                    state_nxt = S_FINISH;
                end
            end
            S_FINISH: begin
                DONE      = 1'b1;
                ERR       = err_flag;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            is_write  <= 1'b0;
            remaining <= 8'd0;
            err_flag  <= 1'b0;
            to_cnt    <= '0;
            RBCP_ADDR <= 32'd0;
            RBCP_WD   <= 8'd0;
            RD_DATA   <= 8'd0;
            RD_VALID  <= 1'b0;
        end else begin
            RD_VALID <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (REQ_VALID) begin
                        is_write  <= REQ_WRITE;
                        remaining <= REQ_LEN;
                        err_flag  <= (REQ_LEN == 8'd0);
                        // A rejected zero-length burst leaves the bus address untouched.
                        if (REQ_LEN != 8'd0) RBCP_ADDR <= REQ_ADDR;
                    end
                end
                S_FETCH: begin
                    if (WR_VALID) RBCP_WD <= WR_DATA;
                end
                S_STROBE: begin
                    to_cnt <= '0;
                end
                S_WAIT_ACK: begin
                    to_cnt <= to_cnt + 1'b1;
                    if (RBCP_ACK) begin
                        RBCP_ADDR <= RBCP_ADDR + 32'd1;
                        remaining <= remaining - 8'd1;
                        if (!is_write) begin
                            RD_DATA  <= RBCP_RD;
                            RD_VALID <= 1'b1;
                        end
                    end else if (timed_out) begin
                        err_flag <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rbcp_initiator.sv
// Self-checking bench for rbcp_initiator: directed corner bursts plus random bursts
// against a responder model and expectations computed from the burst rules.
module tb_rbcp_initiator;

    localparam int TIMEOUT = 8;

    logic        BUS_CLK = 1'b0;
    logic        BUS_RST_N = 1'b0;
    logic        REQ_VALID = 1'b0;
    logic        REQ_READY;
    logic        REQ_WRITE = 1'b0;
    logic [31:0] REQ_ADDR = 32'd0;
    logic [7:0]  REQ_LEN = 8'd0;
    logic [7:0]  WR_DATA = 8'd0;
    logic        WR_VALID = 1'b0;
    logic        WR_READY;
    logic [7:0]  RD_DATA;
    logic        RD_VALID;
    logic        DONE;
    logic        ERR;
    logic        BUSY;
    logic        RBCP_ACT;
    logic [31:0] RBCP_ADDR;
    logic [7:0]  RBCP_WD;
    logic        RBCP_WE;
    logic        RBCP_RE;
    logic        RBCP_ACK = 1'b0;
    logic [7:0]  RBCP_RD = 8'd0;

    rbcp_initiator #(.TIMEOUT(TIMEOUT), .TO_WIDTH(16)) dut (
        .BUS_CLK(BUS_CLK), .BUS_RST_N(BUS_RST_N),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WRITE(REQ_WRITE),
        .REQ_ADDR(REQ_ADDR), .REQ_LEN(REQ_LEN),
        .WR_DATA(WR_DATA), .WR_VALID(WR_VALID), .WR_READY(WR_READY),
        .RD_DATA(RD_DATA), .RD_VALID(RD_VALID),
        .DONE(DONE), .ERR(ERR), .BUSY(BUSY),
        .RBCP_ACT(RBCP_ACT), .RBCP_ADDR(RBCP_ADDR), .RBCP_WD(RBCP_WD),
        .RBCP_WE(RBCP_WE), .RBCP_RE(RBCP_RE), .RBCP_ACK(RBCP_ACK), .RBCP_RD(RBCP_RD)
    );

    always #5 BUS_CLK = ~BUS_CLK;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [7:0]  wd;
        int          cyc;
    } strobe_t;

    int          cyc = 0;
    strobe_t     obs_q[$];
    logic [7:0]  rd_q[$];
    int          done_cnt = 0;
    int          done_cyc = 0;
    logic        done_err, done_act, done_rdv;
    int          act_cnt = 0;
    int          proto_err = 0;
    logic        prev_strobe = 1'b0;
    logic [7:0]  mem [256];
    int          ack_delay = 1;
    bit          burst_over = 0;

    always @(posedge BUS_CLK) cyc <= cyc + 1;

    // Bus monitor: records strobes, read bytes and DONE; flags protocol breaks.
    always @(negedge BUS_CLK) begin
        if (BUS_RST_N) begin
            if (RBCP_WE || RBCP_RE) begin
                obs_q.push_back('{RBCP_ADDR, RBCP_WE, RBCP_WD, cyc});
                if (prev_strobe) proto_err++;
                if (RBCP_WE && RBCP_RE) proto_err++;
                if (!RBCP_ACT) proto_err++;
            end
            prev_strobe = RBCP_WE || RBCP_RE;
            if (RBCP_ACT) act_cnt++;
            if (RD_VALID) rd_q.push_back(RD_DATA);
            if (DONE) begin
                done_cnt++;
                done_cyc = cyc;
                done_err = ERR;
                done_act = RBCP_ACT;
                done_rdv = RD_VALID;
            end
            if (ERR && !DONE) proto_err++;
            if (BUSY == REQ_READY) proto_err++;
            if (WR_READY && !RBCP_ACT) proto_err++;
        end else begin
            prev_strobe = 1'b0;
        end
    end

    // Responder: acks each strobe ack_delay cycles later (never if <= 0).
    initial begin
        logic [31:0] a;
        logic        w;
        logic [7:0]  d;
        forever begin
            @(negedge BUS_CLK);
            if (BUS_RST_N && (RBCP_WE || RBCP_RE)) begin
                a = RBCP_ADDR;
                w = RBCP_WE;
                d = RBCP_WD;
                if (ack_delay > 0) begin
                    repeat (ack_delay) @(negedge BUS_CLK);
                    RBCP_ACK = 1'b1;
                    RBCP_RD  = w ? 8'h00 : mem[a[7:0]];
                    if (w) mem[a[7:0]] = d;
                    @(negedge BUS_CLK);
                    RBCP_ACK = 1'b0;
                    RBCP_RD  = 8'($urandom);
                end
            end
        end
    end

    task automatic feed(input logic [7:0] q[$]);
        foreach (q[i]) begin
            repeat ($urandom_range(1, 2)) begin
                if (burst_over) break;
                @(negedge BUS_CLK);
            end
            if (burst_over) break;
            WR_VALID = 1'b1;
            WR_DATA  = q[i];
            while (!WR_READY && !burst_over) @(negedge BUS_CLK);
            @(negedge BUS_CLK);
            WR_VALID = 1'b0;
            WR_DATA  = 8'($urandom);
        end
        WR_VALID = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int g = 0;
        @(negedge BUS_CLK);
        while (!REQ_READY && g < 100) begin
            @(negedge BUS_CLK);
            g++;
        end
        check({tag, "_ready"}, REQ_READY, 1'b1);
    endtask

    task automatic run_burst(input string tag, input logic wr, input logic [31:0] addr,
                             input int len, input int delay, input logic [7:0] wd_in[$]);
        logic [7:0]  wdata[$];
        logic [7:0]  exp_rd[$];
        logic [31:0] a;
        int          t0, n_exp, exp_lat, g;
        bit          to;
        wdata = wd_in;
        while (wdata.size() < len) wdata.push_back(8'($urandom));
        to    = (len > 0) && (delay <= 0 || delay > TIMEOUT);
        n_exp = (len == 0) ? 0 : (to ? 1 : len);
        if (!wr && !to) begin
            for (int i = 0; i < len; i++) begin
                a = addr + 32'(i);
                exp_rd.push_back(mem[a[7:0]]);
            end
        end
        ack_delay = delay;
        wait_ready(tag);
        obs_q.delete();
        rd_q.delete();
        done_cnt  = 0;
        act_cnt   = 0;
        REQ_VALID = 1'b1;
        REQ_WRITE = wr;
        REQ_ADDR  = addr;
        REQ_LEN   = 8'(len);
        t0        = cyc;
        @(negedge BUS_CLK);
        REQ_VALID = 1'b0;
        REQ_ADDR  = $urandom;
        check({tag, "_ready_low"}, REQ_READY, 1'b0);
        burst_over = 0;
        fork
            begin
                if (wr) feed(wdata);
            end
            begin
                g = 0;
                while (done_cnt == 0 && g < 500) begin
                    @(negedge BUS_CLK);
                    g++;
                end
                burst_over = 1;
            end
        join
        repeat (3) @(negedge BUS_CLK);
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_err"}, done_err, (len == 0) || to);
        check({tag, "_act_at_done"}, done_act, 1'b0);
        check({tag, "_ready_after"}, REQ_READY, 1'b1);
        if (len == 0) begin
            check({tag, "_lat"}, done_cyc - t0, 1);
            check({tag, "_act_cnt"}, act_cnt, 0);
        end else begin
            check({tag, "_act_span"}, act_cnt, done_cyc - t0 - 1);
        end
        if (!wr && len > 0) begin
            exp_lat = to ? 3 + TIMEOUT : 1 + len * (delay + 2);
            check({tag, "_lat"}, done_cyc - t0, exp_lat);
            if (obs_q.size() > 0) check({tag, "_re_cyc"}, obs_q[0].cyc - t0, 2);
            if (!to) check({tag, "_rdv_with_done"}, done_rdv, 1'b1);
        end
        check({tag, "_strobes"}, obs_q.size(), n_exp);
        for (int i = 0; i < n_exp && i < obs_q.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), obs_q[i].addr, addr + 32'(i));
            check($sformatf("%s_we%0d", tag, i), obs_q[i].we, wr);
            if (wr) check($sformatf("%s_wd%0d", tag, i), obs_q[i].wd, wdata[i]);
        end
        check({tag, "_rd_cnt"}, rd_q.size(), exp_rd.size());
        for (int i = 0; i < exp_rd.size() && i < rd_q.size(); i++)
            check($sformatf("%s_rd%0d", tag, i), rd_q[i], exp_rd[i]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [7:0] none[$];
        logic [7:0] t2[$];
        int g;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[8'h10] = 8'hA5;

        #12;
        check("rst_ready", REQ_READY, 1'b1);
        check("rst_outs", {WR_READY, RD_VALID, DONE, ERR, BUSY, RBCP_ACT, RBCP_WE, RBCP_RE}, 8'h00);
        check("rst_data", {RBCP_ADDR, RBCP_WD, RD_DATA} != 48'd0, 1'b0);
        @(negedge BUS_CLK);
        BUS_RST_N = 1'b1;

        run_burst("t1_read1", 1'b0, 32'h10, 1, 1, none);
        t2 = '{8'h11, 8'h22, 8'h33};
        run_burst("t2_write3", 1'b1, 32'h20, 3, 2, t2);
        run_burst("t3_timeout", 1'b0, 32'h30, 2, -1, none);
        run_burst("t3_ack_at_limit", 1'b0, 32'h31, 1, TIMEOUT, none);
        run_burst("t3_ack_late", 1'b0, 32'h32, 1, TIMEOUT + 1, none);
        run_burst("t4_len0", 1'b0, 32'h44, 0, 1, none);
        run_burst("t5_wrap", 1'b0, 32'hFFFF_FFFF, 2, 1, none);

        // Reset while a write strobe waits for an ACK that never comes.
        ack_delay = -1;
        wait_ready("t6");
        obs_q.delete();
        done_cnt  = 0;
        REQ_VALID = 1'b1;
        REQ_WRITE = 1'b1;
        REQ_ADDR  = 32'h40;
        REQ_LEN   = 8'd2;
        @(negedge BUS_CLK);
        REQ_VALID = 1'b0;
        WR_VALID  = 1'b1;
        WR_DATA   = 8'h77;
        g = 0;
        while (!WR_READY && g < 20) begin
            @(negedge BUS_CLK);
            g++;
        end
        @(negedge BUS_CLK);
        WR_VALID = 1'b0;
        g = 0;
        while (obs_q.size() == 0 && g < 20) begin
            @(negedge BUS_CLK);
            g++;
        end
        check("t6_strobe_seen", obs_q.size(), 1);
        @(negedge BUS_CLK);
        check("t6_act_before", RBCP_ACT, 1'b1);
        #2 BUS_RST_N = 1'b0;
        #1;
        check("t6_act_we", {RBCP_ACT, RBCP_WE, RBCP_RE}, 3'b000);
        check("t6_idle", {REQ_READY, BUSY, DONE}, 3'b100);
        check("t6_addr_clr", RBCP_ADDR, 32'd0);
        repeat (3) @(negedge BUS_CLK);
        BUS_RST_N = 1'b1;
        repeat (2) @(negedge BUS_CLK);
        check("t6_no_done", done_cnt, 0);
        run_burst("t6_after", 1'b0, 32'h50, 2, 2, none);

        for (int n = 0; n < 40; n++) begin
            logic        wr;
            logic [31:0] addr;
            int          r, len, delay;
            wr    = 1'($urandom_range(0, 1));
            r     = $urandom_range(0, 9);
            addr  = (r == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 3)) : 32'($urandom);
            len   = (r == 1) ? 0 : $urandom_range(1, 6);
            delay = (r == 2) ? TIMEOUT + 1 : (r == 3) ? TIMEOUT : $urandom_range(1, 4);
            run_burst($sformatf("rnd%0d", n), wr, addr, len, delay, none);
        end

        check("protocol", proto_err, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
